// File: rtl/twos_to_signmag_serial_pkg.sv
// Shared types and helpers for the serial two's-complement to sign-magnitude decoder.
// The FSM encoding is fixed so that other serial codecs can reuse the same state values.
package twos_to_signmag_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Returns the bit-counter width needed to count WIDTH serial steps.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/twos_to_signmag_serial_if.sv
// Ready/valid stream bundle: a two's-complement word goes in, and sign, magnitude
// and the most-negative flag come out.
interface twos_to_signmag_serial_if
    import twos_to_signmag_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_sign;
    logic [WIDTH-1:0] out_mag;
    logic             out_min;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sign, out_mag, out_min
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sign, out_mag, out_min
    );
endinterface

// File: rtl/twos_to_signmag_serial_cell.sv
// One-bit serial negation cell: bits are copied up to and including the first 1,
// and every later bit is inverted. The seen_one flop remembers whether that 1 has passed.
module tc_serial_cell (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic bit_out
);
    logic seen_q;
    logic seen_d;

    always_comb begin
        bit_out = seen_q ? ~bit_in : bit_in;
        seen_d  = seen_q;
        if (clr) begin
            seen_d = 1'b0;
        end else if (en) begin
            seen_d = seen_q | bit_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_q <= 1'b0;
        end else begin
            seen_q <= seen_d;
        end
    end
endmodule

// File: rtl/twos_to_signmag_serial.sv
// Bit-serial two's-complement to sign-magnitude decoder. Non-negative words bypass
// the serial path; negative words are negated LSB first over WIDTH cycles.
module twos_to_signmag_serial
    import twos_to_signmag_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset_p,
    twos_to_signmag_serial_if.slave      bus
);
    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_MAG  = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-2:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             out_sign_q, out_sign_d;
    logic [WIDTH-1:0] out_mag_q, out_mag_d;
    logic             out_min_q, out_min_d;

    logic             accept;
    logic             conv_en;
    logic             res_bit;
    logic [WIDTH-1:0] acc_shift;
    logic [WIDTH-1:0] mag_final;

    tc_serial_cell u_cell (
        .clk     (clk),
        .rst     (reset_p),
        .clr     (accept),
        .en      (conv_en),
        .bit_in  (shreg_q[0]),
        .bit_out (res_bit)
    );

    // Result bits enter at the top and walk down, so bit 0 of the magnitude arrives first.
    assign acc_shift = {res_bit, acc_q};
    assign mag_final = {res_bit, acc_q};

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_sign_d = out_sign_q;
        out_mag_d  = out_mag_q;
        out_min_d  = out_min_q;
        accept     = 1'b0;
        conv_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    accept  = 1'b1;
                    shreg_d = bus.in_data;
                    acc_d   = '0;
                    cnt_d   = '0;
                    if (!bus.in_data[WIDTH-1]) begin
                        state_d    = ST_DONE;
                        out_sign_d = 1'b0;
                        out_mag_d  = bus.in_data;
                        out_min_d  = 1'b0;
                    end else begin
                        state_d = ST_CONV;
                    end
                end
            end
            ST_CONV: begin
                conv_en = 1'b1;
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                acc_d   = acc_shift[WIDTH-1:1];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d    = ST_DONE;
                    cnt_d      = '0;
                    out_sign_d = 1'b1;
                    out_mag_d  = mag_final;
                    // Only the most negative word negates to a lone MSB.
                    out_min_d  = (mag_final == MIN_MAG);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d    = ST_IDLE;
                    out_sign_d = 1'b0;
                    out_mag_d  = '0;
                    out_min_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_mag_q   <= '0;
            out_min_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_sign_q  <= out_sign_d;
            out_mag_q   <= out_mag_d;
            out_min_q   <= out_min_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sign  = out_sign_q;
    assign bus.out_mag   = out_mag_q;
    assign bus.out_min   = out_min_q;
endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// Directed and exhaustive bench for the serial two's-complement to sign-magnitude decoder.
module tb_twos_to_signmag_serial;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset_p;

    always #5 clk = ~clk;

    twos_to_signmag_serial_if #(.WIDTH(W)) bus ();

    twos_to_signmag_serial #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_p (reset_p),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] din;
        logic       esign;
        logic [7:0] emag;
        logic       emin;
        int         elat;
        int         hold;
        logic       rdy_early;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_word(input logic [7:0] din, input logic esign, input logic [7:0] emag,
                            input logic emin, input int elat, input int hold, input logic rdy_early);
        int lat;
        int guard;
        guard = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_before_send", 32'(bus.in_ready), 32'd1);
        bus.out_ready = rdy_early;
        bus.in_valid  = 1'b1;
        bus.in_data   = din;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            bus.in_valid = 1'b0;
        end while (bus.out_valid !== 1'b1 && lat < 40);
        check("latency", 32'(lat), 32'(elat));
        check("out_sign", 32'(bus.out_sign), 32'(esign));
        check("out_mag", 32'(bus.out_mag), 32'(emag));
        check("out_min", 32'(bus.out_min), 32'(emin));
        bus.out_ready = (hold == 0);
        for (int k = 0; k < hold; k++) begin
            // Offer a stray word while busy; it must not be taken.
            bus.in_valid = (k < hold - 1);
            bus.in_data  = 8'h11;
            @(negedge clk);
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("hold_out_mag", 32'(bus.out_mag), 32'(emag));
            check("hold_out_sign", 32'(bus.out_sign), 32'(esign));
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            if (k == hold - 1) bus.out_ready = 1'b1;
        end
        @(negedge clk);
        check("release_out_valid", 32'(bus.out_valid), 32'd0);
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] x;
        logic [7:0] emag;

        vecs[0] = '{8'h05, 1'b0, 8'h05, 1'b0, 1, 0, 1'b1};
        vecs[1] = '{8'hFB, 1'b1, 8'h05, 1'b0, 9, 0, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 8'h01, 1'b0, 9, 0, 1'b1};
        vecs[3] = '{8'h9C, 1'b1, 8'h64, 1'b0, 9, 1, 1'b0};
        vecs[4] = '{8'h80, 1'b1, 8'h80, 1'b1, 9, 0, 1'b0};
        vecs[5] = '{8'h00, 1'b0, 8'h00, 1'b0, 1, 0, 1'b0};
        vecs[6] = '{8'h7F, 1'b0, 8'h7F, 1'b0, 1, 0, 1'b1};
        vecs[7] = '{8'h81, 1'b1, 8'h7F, 1'b0, 9, 0, 1'b0};
        vecs[8] = '{8'hF0, 1'b1, 8'h10, 1'b0, 9, 5, 1'b0};
        vecs[9] = '{8'h01, 1'b0, 8'h01, 1'b0, 1, 2, 1'b1};

        reset_p       = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_out_sign", 32'(bus.out_sign), 32'd0);
        check("reset_out_mag", 32'(bus.out_mag), 32'd0);
        check("reset_out_min", 32'(bus.out_min), 32'd0);
        reset_p = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_word(vecs[i].din, vecs[i].esign, vecs[i].emag, vecs[i].emin,
                     vecs[i].elat, vecs[i].hold, vecs[i].rdy_early);
        end

        // Reset in the middle of a negative conversion.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hC3;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("midconv_busy", 32'(bus.in_ready), 32'd0);
        reset_p = 1'b1;
        @(negedge clk);
        reset_p = 1'b0;
        check("midconv_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midconv_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midconv_rst_out_sign", 32'(bus.out_sign), 32'd0);
        check("midconv_rst_out_mag", 32'(bus.out_mag), 32'd0);
        check("midconv_rst_out_min", 32'(bus.out_min), 32'd0);
        run_word(8'h3D, 1'b0, 8'h3D, 1'b0, 1, 0, 1'b0);

        // Every input in order, with random backpressure.
        for (int v = 0; v < 256; v++) begin
            x    = 8'(v);
            emag = x[7] ? 8'(~x + 8'd1) : x;
            run_word(x, x[7], emag, (x == 8'h80), x[7] ? 9 : 1,
                     int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
